// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, register map, STATUS layout.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Word offsets within the 16-byte register window (addr[3:2])
    localparam logic [1:0] RegTxData  = 2'd0;
    localparam logic [1:0] RegStatus  = 2'd1;
    localparam logic [1:0] RegBaudDiv = 2'd2;

    // STATUS bit positions
    localparam int unsigned StatusBusy     = 0;
    localparam int unsigned StatusFull     = 1;
    localparam int unsigned StatusEmpty    = 2;
    localparam int unsigned StatusOvf      = 3;
    localparam int unsigned StatusLevelLsb = 4;
    localparam int unsigned StatusLevelW   = 4;

    function automatic logic [31:0] status_word(
        input logic [StatusLevelW-1:0] level,
        input logic                    ovf,
        input logic                    empty,
        input logic                    full,
        input logic                    busy
    );
        logic [31:0] w;
        w = '0;
        w[StatusLevelLsb +: StatusLevelW] = level;
        w[StatusOvf]   = ovf;
        w[StatusEmpty] = empty;
        w[StatusFull]  = full;
        w[StatusBusy]  = busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational read port; extra pointer bit separates full from empty.
module uart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       din,
    output logic [Width-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] level
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW:0]   wr_ptr_q;
    logic [AddrW:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem[rd_ptr_q[AddrW-1:0]];

    // A pop in the same cycle frees a slot, so a push on full is still accepted
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; reset discards contents by realigning the pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: register slave on ic0, TX FIFO, 8N1 serialiser.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] RST_DIV    = 16'd867
) (
    input  logic        clk,
    input  logic        c_sys_rst,
    input  logic        ic0_c_axi_mst_wr_valid,
    input  logic [31:0] ic0_axi_mst_wr_addr,
    input  logic [31:0] ic0_axi_mst_wr_data,
    input  logic [3:0]  ic0_axi_mst_wr_strobe,
    input  logic        ic0_c_axi_mst_rd_valid,
    input  logic [31:0] ic0_axi_mst_rd_addr,
    output logic        ic0_c_axi_slv_rd_ready_3,
    output logic [31:0] ic0_axi_slv_rd_data_3,
    output logic        uart_txd_o
);

    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       wr_hit;
    logic       rd_hit;
    logic [1:0] wr_off;
    logic [1:0] rd_off;
    logic       push_req;
    logic       status_rd;
    logic       ovf_set;

    // Registers
    logic [15:0] baud_div_q;
    logic        ovf_q;
    logic        rd_ready_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_word;

    // FIFO
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [LevelW-1:0] fifo_level;
    logic [3:0]        level_field;

    // Serialiser
    tx_state_e   state_q;
    logic [7:0]  shift_q;
    logic [15:0] div_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic        txd_q;
    logic        frame_start;
    logic        pop;

    assign wr_hit    = ic0_c_axi_mst_wr_valid && (ic0_axi_mst_wr_addr[31:4] == BASE_ADDR[31:4]);
    assign rd_hit    = ic0_c_axi_mst_rd_valid && (ic0_axi_mst_rd_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_off    = ic0_axi_mst_wr_addr[3:2];
    assign rd_off    = ic0_axi_mst_rd_addr[3:2];
    assign push_req  = wr_hit && (wr_off == RegTxData) && ic0_axi_mst_wr_strobe[0];
    assign status_rd = rd_hit && (rd_off == RegStatus);
    // A concurrent pop makes room, so only an unserviced push on full is an overflow
    assign ovf_set   = push_req && fifo_full && !pop;

    logic unused_bits;
    assign unused_bits = ^{ic0_axi_mst_wr_data[31:16], ic0_axi_mst_wr_addr[1:0],
                           ic0_axi_mst_wr_strobe[3:2], ic0_axi_mst_rd_addr[1:0]};

    uart_fifo #(
        .Width(8),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (c_sys_rst),
        .push (push_req),
        .pop  (pop),
        .din  (ic0_axi_mst_wr_data[7:0]),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    assign level_field = 4'(fifo_level);

    // Read data mux for the addressed register
    always_comb begin
        rd_word = '0;
        case (rd_off)
            RegStatus:  rd_word = status_word(level_field, ovf_q, fifo_empty, fifo_full,
                                              state_q != StIdle);
            RegBaudDiv: rd_word = {16'h0000, baud_div_q};
            default:    rd_word = '0;
        endcase
    end

    // Register file, sticky overflow and one-cycle read response
    always_ff @(posedge clk or posedge c_sys_rst) begin
        if (c_sys_rst) begin
            baud_div_q <= RST_DIV;
            ovf_q      <= 1'b0;
            rd_ready_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (wr_hit && (wr_off == RegBaudDiv)) begin
                if (ic0_axi_mst_wr_strobe[0]) baud_div_q[7:0]  <= ic0_axi_mst_wr_data[7:0];
                if (ic0_axi_mst_wr_strobe[1]) baud_div_q[15:8] <= ic0_axi_mst_wr_data[15:8];
            end
            // Overflow in the clearing cycle takes priority
            ovf_q      <= ovf_set | (ovf_q & ~status_rd);
            rd_ready_q <= rd_hit;
            rd_data_q  <= rd_hit ? rd_word : '0;
        end
    end

    assign ic0_c_axi_slv_rd_ready_3 = rd_ready_q;
    assign ic0_axi_slv_rd_data_3    = rd_data_q;

    // New frame begins from idle, or straight out of the last stop-bit cycle
    assign frame_start = !fifo_empty &&
                         ((state_q == StIdle) || ((state_q == StStop) && (cnt_q == '0)));
    assign pop = frame_start;

    // Serialiser FSM; each bit lasts div_q+1 cycles via a reloading down-counter
    always_ff @(posedge clk or posedge c_sys_rst) begin
        if (c_sys_rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else if (frame_start) begin
            shift_q   <= fifo_dout;
            div_q     <= baud_div_q;
            cnt_q     <= baud_div_q;
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            state_q   <= StStart;
        end else begin
            case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                end
                StStart: begin
                    if (cnt_q == '0) begin
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= '0;
                        cnt_q     <= div_q;
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == '0) begin
                        cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uart_txd_o = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected frames and read responses are queued at issue time
// and retired by independent serial and read-bus monitors.
module tb_uart_tx;

    localparam logic [31:0] Base = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        c_sys_rst;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        txd;

    uart_tx #(
        .BASE_ADDR (Base),
        .FIFO_DEPTH(8),
        .RST_DIV   (16'd867)
    ) dut (
        .clk                     (clk),
        .c_sys_rst               (c_sys_rst),
        .ic0_c_axi_mst_wr_valid  (wr_valid),
        .ic0_axi_mst_wr_addr     (wr_addr),
        .ic0_axi_mst_wr_data     (wr_data),
        .ic0_axi_mst_wr_strobe   (wr_strobe),
        .ic0_c_axi_mst_rd_valid  (rd_valid),
        .ic0_axi_mst_rd_addr     (rd_addr),
        .ic0_c_axi_slv_rd_ready_3(rd_ready),
        .ic0_axi_slv_rd_data_3   (rd_data),
        .uart_txd_o              (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    typedef struct {
        int          due;
        logic        ready;
        logic [31:0] data;
    } rd_t;

    frame_t      ser_q[$];
    rd_t         rd_q[$];
    int          start_cyc[$];
    int          frames_started = 0;
    logic [15:0] model_baud = 16'd867;
    bit          drop_push = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Serial monitor: expected waveform is start(0), 8 data bits LSB first, stop(1), div+1 each
    bit         in_frame = 1'b0;
    bit         junk = 1'b0;
    bit         frame_ok;
    frame_t     cur;
    int         pos;
    int         bitn;
    logic       expb;
    logic [7:0] rx_byte;
    logic [7:0] cur_data;

    always @(negedge clk) begin
        if (c_sys_rst) begin
            in_frame = 1'b0;
            junk     = 1'b0;
            ser_q.delete();
            check("txd_in_reset", {31'b0, txd}, 32'd1);
        end else begin
            if (junk && txd) junk = 1'b0;
            if (!in_frame && !junk && txd == 1'b0) begin
                if (ser_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    junk = 1'b1;
                    $display("FAIL unexpected_start: got start bit expected idle line (cycle %0d)",
                             cyc);
                end else begin
                    cur      = ser_q.pop_front();
                    in_frame = 1'b1;
                    pos      = 0;
                    frame_ok = 1'b1;
                    rx_byte  = 8'h00;
                    frames_started++;
                    start_cyc.push_back(cyc);
                end
            end
            if (in_frame) begin
                cur_data = cur.data;
                bitn = pos / (cur.div + 1);
                if (bitn == 0)      expb = 1'b0;
                else if (bitn == 9) expb = 1'b1;
                else                expb = cur_data[bitn-1];
                if (txd !== expb) frame_ok = 1'b0;
                if (bitn >= 1 && bitn <= 8 && (pos % (cur.div + 1)) == 0) rx_byte[bitn-1] = txd;
                pos++;
                if (pos == 10 * (cur.div + 1)) begin
                    in_frame = 1'b0;
                    check("serial_frame", {23'b0, frame_ok, rx_byte}, {23'b0, 1'b1, cur.data});
                end
            end
        end
    end

    // Read monitor: each issued read is due exactly one cycle later
    rd_t re;
    always @(negedge clk) begin
        if (c_sys_rst) begin
            rd_q.delete();
        end else if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            re = rd_q.pop_front();
            check("rd_ready", {31'b0, rd_ready}, {31'b0, re.ready});
            check("rd_data", rd_data, re.data);
        end else if (rd_ready) begin
            check("rd_unexpected", {31'b0, rd_ready}, 32'd0);
        end
    end

    // One bus cycle; expectations are queued from the register-map rules at issue time
    task automatic bus(input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input bit rd, input logic [31:0] ra,
                       input logic [31:0] st_exp);
        rd_t    e;
        frame_t f;
        @(negedge clk);
        wr_valid  = wr;
        wr_addr   = wa;
        wr_data   = wd;
        wr_strobe = ws;
        rd_valid  = rd;
        rd_addr   = ra;
        if (rd) begin
            e.due = cyc + 1;
            if (ra[31:4] != Base[31:4]) begin
                e.ready = 1'b0;
                e.data  = '0;
            end else begin
                e.ready = 1'b1;
                case (ra[3:2])
                    2'd1:    e.data = st_exp;
                    2'd2:    e.data = {16'h0000, model_baud};
                    default: e.data = '0;
                endcase
            end
            rd_q.push_back(e);
        end
        if (wr && wa[31:4] == Base[31:4]) begin
            if (wa[3:2] == 2'd0 && ws[0]) begin
                if (drop_push) begin
                    drop_push = 1'b0;
                end else begin
                    f.data = wd[7:0];
                    f.div  = int'(model_baud);
                    ser_q.push_back(f);
                end
            end else if (wa[3:2] == 2'd2) begin
                if (ws[0]) model_baud[7:0]  = wd[7:0];
                if (ws[1]) model_baud[15:8] = wd[15:8];
            end
        end
    endtask

    task automatic idle();
        bus(1'b0, '0, '0, 4'h0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, a, d, s, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] st_exp);
        bus(1'b0, '0, '0, 4'h0, 1'b1, a, st_exp);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ser_q.size() == 0 && !in_frame) return;
            idle();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d frames pending expected 0", ser_q.size());
    endtask

    task automatic wait_start(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames_started > n) return;
            idle();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL start_timeout: got %0d starts expected more than %0d", frames_started, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    int c0;
    int s0;
    int target;

    initial begin
        c_sys_rst = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_strobe = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_ready", {31'b0, rd_ready}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        c_sys_rst = 1'b0;

        // Reset register values and map holes; a miss gives no ready
        rd(Base + 32'h4, 32'h0000_0004);
        rd(Base + 32'h8, 32'h0);
        rd(Base + 32'h10, 32'h0);
        rd(Base + 32'h0, 32'h0);
        rd(Base + 32'hC, 32'h0);
        idle();

        // 0xA5 at div 3: 40-cycle frame, busy drops right after the stop bit
        wr(Base + 32'h8, 32'h0000_0003, 4'b0011);
        wr(Base + 32'h0, 32'h0000_00A5, 4'b0001);
        for (int i = 0; i < 10 && txd !== 1'b0; i++) idle();
        c0 = cyc;
        repeat (38) idle();
        rd(Base + 32'h4, 32'h0000_0005);
        rd(Base + 32'h4, 32'h0000_0004);
        check("a5_start_offset", cyc - c0, 32'd40);
        wait_drain(100);

        // Two queued bytes run back to back
        s0 = start_cyc.size();
        wr(Base + 32'h0, 32'h0000_0001, 4'b0001);
        wr(Base + 32'h0, 32'h0000_0002, 4'b0001);
        wait_drain(200);
        if (start_cyc.size() >= s0 + 2)
            check("no_gap", start_cyc[s0+1] - start_cyc[s0], 32'd40);
        else
            check("no_gap_frames", start_cyc.size() - s0, 32'd2);

        // Rate change mid-frame applies from the next frame
        wr(Base + 32'h8, 32'h0000_0005, 4'b0011);
        s0 = start_cyc.size();
        wr(Base + 32'h0, 32'h0000_003C, 4'b0001);
        repeat (3) idle();
        wr(Base + 32'h8, 32'hFFFF_0001, 4'b0001);
        wr(Base + 32'h0, 32'h0000_00C3, 4'b0001);
        rd(Base + 32'h8, 32'h0);
        wait_drain(300);
        if (start_cyc.size() >= s0 + 2)
            check("rate_gap", start_cyc[s0+1] - start_cyc[s0], 32'd60);
        else
            check("rate_frames", start_cyc.size() - s0, 32'd2);

        // Consecutive reads and a miss
        rd(Base + 32'h4, 32'h0000_0004);
        rd(Base + 32'h8, 32'h0);
        rd(Base + 32'h10, 32'h0);
        idle();

        // Overflow: one byte in flight, then 9 writes into an 8-deep FIFO
        wr(Base + 32'h8, 32'h0000_0064, 4'b0011);
        s0 = start_cyc.size();
        wr(Base + 32'h0, 32'h0000_0011, 4'b0001);
        repeat (3) idle();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) drop_push = 1'b1;
            wr(Base + 32'h0, 32'h20 + i, 4'b0001);
        end
        // Read clear and a fresh overflow in the same cycle: overflow wins
        drop_push = 1'b1;
        bus(1'b1, Base, 32'h0000_0099, 4'b0001, 1'b1, Base + 32'h4, 32'h0000_008B);
        rd(Base + 32'h4, 32'h0000_008B);
        rd(Base + 32'h4, 32'h0000_0083);
        // Push on full exactly when the next frame pops: accepted, no overflow
        if (start_cyc.size() > s0) begin
            target = start_cyc[s0] + 1010 - 1;
            while (cyc < target - 1) idle();
            wr(Base + 32'h0, 32'h0000_0077, 4'b0001);
            rd(Base + 32'h4, 32'h0000_0083);
        end else begin
            check("ovf_first_start", start_cyc.size() - s0, 32'd1);
        end
        wait_drain(12000);

        // Reset during data bit 3 of 0xF0 with 0x55 still queued
        wr(Base + 32'h8, 32'h0000_0003, 4'b0011);
        s0 = frames_started;
        wr(Base + 32'h0, 32'h0000_00F0, 4'b0001);
        wr(Base + 32'h0, 32'h0000_0055, 4'b0001);
        wait_start(s0, 20);
        c0 = start_cyc[start_cyc.size()-1];
        while (cyc < c0 + 17) idle();
        check("txd_bit3_low", {31'b0, txd}, 32'd0);
        #2;
        c_sys_rst  = 1'b1;
        model_baud = 16'd867;
        drop_push  = 1'b0;
        #1;
        check("txd_async_reset", {31'b0, txd}, 32'd1);
        repeat (2) @(negedge clk);
        c_sys_rst = 1'b0;
        rd(Base + 32'h4, 32'h0000_0004);
        rd(Base + 32'h8, 32'h0);
        repeat (20) idle();

        // Randomised groups: program a small divider, then a mix of pushes and ignored traffic
        for (int g = 0; g < 20; g++) begin
            wr(Base + 32'h8, {$urandom_range(0, 65535), 8'h00, 8'($urandom_range(0, 4))},
               {2'($urandom_range(0, 3)), 2'b11});
            for (int k = 0; k < $urandom_range(1, 6); k++) begin
                repeat ($urandom_range(0, 2)) idle();
                case ($urandom_range(0, 9))
                    0: wr(Base, $urandom, {3'($urandom_range(0, 7)), 1'b0});
                    1: wr(Base + 32'h10 * $urandom_range(1, 15), $urandom, 4'hF);
                    2: rd(Base + 32'h4 * $urandom_range(2, 7), 32'h0);
                    3: wr(Base + 32'h4 * $urandom_range(1, 3) + 32'h4 * 32'($urandom_range(0, 1)),
                          $urandom, 4'h0);
                    default: bus(1'b1, Base, $urandom, 4'h1 | 4'($urandom_range(0, 15)),
                                 1'($urandom_range(0, 1)), Base + 32'h8, 32'h0);
                endcase
            end
            wait_drain(600);
        end

        repeat (5) idle();
        check("rd_queue_empty", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
